// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: lane indices, default
// auto-repeat mask and 50 MHz cycle constants.
package btn_pkg;

  localparam int NUM_BTN_C = 8;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_RIGHT  = 3'd4,
    BTN_LEFT   = 3'd5,
    BTN_UP     = 3'd6,
    BTN_DOWN   = 3'd7
  } btn_idx_e;

  // Right, Left and Down auto-repeat; the others fire once per press.
  localparam logic [NUM_BTN_C-1:0] REPEAT_MASK_C = 8'b1011_0000;

  // Cycle counts at a 50 MHz system clock.
  localparam int DEBOUNCE_10MS = 500000;
  localparam int REPEAT_250MS  = 12500000;
  localparam int REPEAT_50MS   = 2500000;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_lane.sv
// One button lane: 2-flop synchroniser, debounce counter and registered
// press/release pulses that coincide with the debounced level change.
module btn_debounce_lane
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic resetN,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic rls
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops hold the active-low raw value; reset means released.
  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rls_q, rls_d;
  logic             s;

  // Next-state: synchronise, count disagreement with the stable value, flip once it has held long enough.
  always_comb begin
    meta_d   = raw_n;
    sync_d   = meta_q;
    s        = ~sync_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    rls_d    = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s;
        press_d  = s;
        rls_d    = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset aborts any count in progress.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rls_q    <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rls_q    <= rls_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;
  assign rls   = rls_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: debounced levels, press/release pulses and
// auto-repeat move pulses for the game logic.
// Optional macro BTN_AUTOREPEAT_EN enables the per-lane repeat FSMs on
// REPEAT_MASK lanes; without it btn_move equals btn_press on every lane.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int                 NUM_BTN         = NUM_BTN_C,
  parameter int                 DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int                 REPEAT_DELAY    = REPEAT_250MS,
  parameter int                 REPEAT_RATE     = REPEAT_50MS,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = REPEAT_MASK_C
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_BTN-1:0] btn_rawN,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_move
);

  // All cycle counts must be at least one.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      $bits(REPEAT_MASK) != NUM_BTN) begin : g_param_check
    $error("button_conditioner: invalid parameters");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane

    btn_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk   (clk),
      .resetN(resetN),
      .raw_n (btn_rawN[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rls   (btn_release[i])
    );

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rpt
      rpt_state_e        state_q, state_d;
      logic [RCNT_W-1:0] rcnt_q, rcnt_d;
      logic              move;

      // Repeat FSM state and interval counter.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // Move on press, after the initial delay, then at the repeat rate; release wins over a tick.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        move    = 1'b0;
        unique case (state_q)
          RPT_IDLE: begin
            rcnt_d = '0;
            if (btn_press[i]) begin
              move    = 1'b1;
              state_d = RPT_DELAY;
            end
          end
          RPT_DELAY: begin
            if (btn_release[i]) begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == DELAY_LAST) begin
              move    = 1'b1;
              state_d = RPT_REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (btn_release[i]) begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == RATE_LAST) begin
              move   = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          default: begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      assign btn_move[i] = move;
    end else begin : g_norpt
      assign btn_move[i] = btn_press[i];
    end
`else
    assign btn_move[i] = btn_press[i];
`endif

  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner with a history-based reference
// model feeding a scoreboard queue checked by an independent monitor.
module tb_button_conditioner;

  localparam int             NB   = 8;
  localparam int             DEB  = 4;
  localparam int             RD   = 10;
  localparam int             RR   = 3;
  localparam logic [NB-1:0]  RMSK = 8'b1011_0000;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int MAXC = 16384;

  logic          clk;
  logic          resetN;
  logic [NB-1:0] btn_rawN;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_move;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_MASK    (RMSK)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .btn_rawN   (btn_rawN),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_move   (btn_move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] mov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: per-edge history of sampled raw inputs and of
  // the debounced level, plus the edge index of each lane's last press.
  logic [NB-1:0] raw_h  [MAXC];
  logic [NB-1:0] stab_h [MAXC];
  int            last_press [NB];
  int            n        = 16;
  int            rst_last = 16;

  // Active-high synchronised value visible during cycle j.
  function automatic logic [NB-1:0] s_at(input int j);
    if (j <= rst_last) return '0;
    return ~raw_h[j-1];
  endfunction

  initial begin
    for (int j = 0; j < MAXC; j++) begin
      raw_h[j]  = '1;
      stab_h[j] = '0;
    end
    for (int i = 0; i < NB; i++) last_press[i] = -1;
  end

  // Model: a lane's level flips when the synchronised input has disagreed
  // with an unchanged level for the last DEB cycles. Masked lanes move at
  // press, press+RD, then every RR cycles while still held.
  exp_t          m_e;
  logic [NB-1:0] m_prev, m_nst, m_s;
  bit            m_flip;
  int            m_d;
  always @(posedge clk) begin
    if (n < MAXC - 1) n = n + 1;
    m_e = '0;
    if (!resetN) begin
      raw_h[n]  = '1;
      stab_h[n] = '0;
      rst_last  = n;
      for (int i = 0; i < NB; i++) last_press[i] = -1;
    end else begin
      raw_h[n] = btn_rawN;
      m_prev   = stab_h[n-1];
      m_nst    = m_prev;
      for (int i = 0; i < NB; i++) begin
        m_flip = 1'b1;
        for (int k = 1; k <= DEB; k++) begin
          m_s = s_at(n - k);
          if (m_s[i] == stab_h[n-k][i] || stab_h[n-k][i] != m_prev[i]) m_flip = 1'b0;
        end
        m_nst[i]  = m_prev[i] ^ m_flip;
        m_e.prs[i] = m_flip & ~m_prev[i];
        m_e.rel[i] = m_flip & m_prev[i];
        if (m_e.prs[i]) last_press[i] = n;
        m_e.mov[i] = m_e.prs[i];
        m_d = n - last_press[i];
        if (AUTO && RMSK[i] && m_nst[i] && last_press[i] >= 0 &&
            (m_d == RD || (m_d > RD && ((m_d - RD) % RR) == 0)))
          m_e.mov[i] = 1'b1;
      end
      stab_h[n] = m_nst;
      m_e.lvl   = m_nst;
    end
    exp_q.push_back(m_e);
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, req);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("level",   btn_level,   mon_e.lvl);
      chk("press",   btn_press,   mon_e.prs);
      chk("release", btn_release, mon_e.rel);
      chk("move",    btn_move,    mon_e.mov);
    end
  end

  task automatic drive(input logic [NB-1:0] r, input logic rn, input int cyc);
    @(negedge clk);
    #1;
    btn_rawN = r;
    resetN   = rn;
    repeat (cyc - 1) @(negedge clk);
  endtask

  logic [NB-1:0] rnd_raw;
  initial begin
    btn_rawN = '1;
    resetN   = 1'b0;
    drive(8'hFF, 1'b0, 4);
    drive(8'hFF, 1'b1, 5);
    // Left held into repeat, then released during REPEAT
    drive(8'hDF, 1'b1, 30);
    drive(8'hFF, 1'b1, 15);
    // A glitch shorter than the debounce window
    drive(8'hFE, 1'b1, 3);
    drive(8'hFF, 1'b1, 10);
    // A held for 100 cycles
    drive(8'hFE, 1'b1, 100);
    drive(8'hFF, 1'b1, 10);
    // Down repeating, reset mid-repeat with the button still held
    drive(8'h7F, 1'b1, 25);
    drive(8'h7F, 1'b0, 3);
    drive(8'h7F, 1'b1, 30);
    drive(8'hFF, 1'b1, 10);
    // Right held 50 cycles
    drive(8'hEF, 1'b1, 50);
    drive(8'hFF, 1'b1, 10);
    // Left and Right together
    drive(8'hCF, 1'b1, 30);
    drive(8'hFF, 1'b1, 10);
    // Glitches of exactly DEB-1 and DEB cycles on B
    drive(8'hFD, 1'b1, DEB - 1);
    drive(8'hFF, 1'b1, 8);
    drive(8'hFD, 1'b1, DEB);
    drive(8'hFF, 1'b1, 12);
    // Random segments with occasional resets
    rnd_raw = 8'hFF;
    for (int seg = 0; seg < 160; seg++) begin
      rnd_raw = rnd_raw ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 39) == 0)
        drive(rnd_raw, 1'b0, $urandom_range(1, 3));
      drive(rnd_raw, 1'b1, $urandom_range(1, 12));
    end
    drive(8'hFF, 1'b1, 20);
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL queue_depth got=%0d want<=1", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly downstream of the analog-to-button decoder and consumes its eight active-low button levels (A, B, Select, Start, Right, Left, Up, Down).
- Synchronises and debounces each button.
- Produces clean pressed levels, one-cycle press pulses, and Tetris-style auto-repeat "move" pulses for the game-logic FSMs.
- The wheel value is not handled here.

Parameters:
- NUM_BTN, 8: number of button lanes. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Right, 5 Left, 6 Up, 7 Down.
- DEBOUNCE_CYCLES, 500000: cycles a new synchronised value must hold before it is accepted (10 ms at 50 MHz). Minimum 1.
- REPEAT_DELAY, 12500000: cycles from press pulse to first repeat pulse (250 ms). Minimum 1.
- REPEAT_RATE, 2500000: cycles between subsequent repeat pulses (50 ms). Minimum 1.
- REPEAT_MASK, 8'b1011_0000: lanes with auto-repeat (Right, Left, Down).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- btn_rawN  in  NUM_BTN  raw buttons from decoder; 0 = pressed; asynchronous to clk
- btn_level  out  NUM_BTN  debounced level; 1 = pressed
- btn_press  out  NUM_BTN  one-cycle pulse on debounced release-to-press transition
- btn_release  out  NUM_BTN  one-cycle pulse on debounced press-to-release transition
- btn_move  out  NUM_BTN  press pulse plus auto-repeat pulses (masked lanes only; other lanes equal btn_press)

Behaviour:
- Reset (resetN=0, asynchronous):
  - All synchroniser flops = 1 (released).
  - All counters = 0; all repeat FSMs = IDLE.
  - All outputs = 0.
  - Reset asserted mid-press or mid-repeat aborts immediately. After release of reset, a held button is seen as a new press after normal latency.
- Synchroniser: 2-flop per lane. s[i] at cycle t equals btn_rawN[i] at t-2, inverted to active-high.
- Debounce, per lane, counter width $clog2(DEBOUNCE_CYCLES+1):
  - s == stable: counter cleared.
  - s != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != stable and counter == DEBOUNCE_CYCLES-1: stable flips on the next edge and counter clears.
  - Any glitch back to stable before the count completes clears the counter (no partial credit).
- Latency: a clean raw edge at cycle 0 appears on btn_level at cycle DEBOUNCE_CYCLES+2.
- btn_press[i] = stable rises; btn_release[i] = stable falls. Each is registered with the same timing as btn_level, so the pulse is coincident with the level change.
- Repeat FSM, per masked lane. States are IDLE, DELAY, REPEAT; rcnt width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE: on btn_press, btn_move pulses the same cycle, go to DELAY, rcnt=0.
  - DELAY: rcnt increments. When rcnt == REPEAT_DELAY-1, btn_move pulses, go to REPEAT, rcnt=0.
  - REPEAT: rcnt increments. When rcnt == REPEAT_RATE-1, btn_move pulses, rcnt=0; remains in REPEAT.
  - Debounced release in DELAY or REPEAT: go to IDLE with no pulse that cycle. Release has priority over a coincident repeat tick.
- Lanes are fully independent. Simultaneous Left+Right both produce move pulses; arbitration belongs to game logic.
- Unmasked lanes: btn_move = btn_press, and the FSM is optimised away.
- Counters never wrap. Every count is bounded by an explicit compare-and-clear.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: repeat FSMs are instantiated as above.
- Undefined: no repeat FSMs or rcnt registers; btn_move = btn_press on all lanes. Level, press, and release behaviour is unchanged.

Decomposition:
- Shared package btn_pkg:
  - enum btn_idx_e (BTN_A=0 … BTN_DOWN=7)
  - localparam NUM_BTN_C=8
  - default REPEAT_MASK_C
  - 50 MHz-derived cycle constants (DEBOUNCE_10MS, REPEAT_250MS, REPEAT_50MS)
- One sub-module, btn_debounce_lane: synchroniser, debounce counter, and press/release pulse generation for a single lane. The top instantiates it NUM_BTN times via generate. The repeat FSM lives in the top under the macro.

Test Plan (run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, macro defined):
- Reset with btn_rawN=8'hFF, then drop bit 5 (Left) to 0 at cycle 0 and hold → btn_level[5]=1 and btn_press[5]=btn_move[5]=1 at cycle 6; btn_move[5] pulses again at 16, 19, 22…
- Bit 0 (A) low for 3 cycles then high (glitch) → btn_level[0] stays 0; no press pulse.
- Hold Left, then release at the raw input during REPEAT → btn_release[5] pulses 6 cycles later; no btn_move pulse from that cycle on.
- Hold A (unmasked) for 100 cycles → exactly one btn_press[0] and one btn_move[0]; no repeats.
- Assert resetN=0 during Down repeat with raw still pressed, release reset → all outputs 0 during reset; fresh btn_press[7] 6 cycles after reset release.
- Rebuild without BTN_AUTOREPEAT_EN, hold Right 50 cycles → single btn_move[4] pulse coincident with btn_press[4].
